// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, sync polarity enum and sync bundle.
// Holds the 640x480@60 default set and an 800x600@60 alternate set.
package vga_pkg;

  typedef enum logic {
    SYNC_LOW  = 1'b0,
    SYNC_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
  } sync_t;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

  localparam int BAR_CNT = 8;

  function automatic int vga_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// vga_tick_div: clock-enable divider, one strobe every TICK_DIV enabled clks.
// The pending strobe is held while en is low so resume keeps the cadence.
module vga_tick_div #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic p_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;
  logic          pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      pend     <= 1'b0;
    end else if (en) begin
      pend     <= (tick_cnt == LAST);
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  assign p_tick = pend & en;

endmodule

// File: rtl/vga_timing_gen_p.sv
// vga_timing_gen_p: parametrised VGA timing with aligned sync/blank and RGB reg.
// Optional VGA_TEST_PATTERN_EN adds test_en and an 8-bar colour pattern.
module vga_timing_gen_p
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int SYNC_POL = 0,
  parameter int TICK_DIV = 2,
  parameter int PIPE     = 1,
  parameter int RGB_W    = 3,
  parameter int XY_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  input  logic [RGB_W-1:0] rgb_in,
  output logic [XY_W-1:0]  pixel_x,
  output logic [XY_W-1:0]  pixel_y,
  output logic             p_tick,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] rgb
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [XY_W-1:0] H_LAST = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] V_LAST = XY_W'(V_TOTAL - 1);

  localparam logic [XY_W:0] H_VIS  = (XY_W+1)'(H_ACTIVE);
  localparam logic [XY_W:0] HS_ON  = (XY_W+1)'(H_ACTIVE + H_FP);
  localparam logic [XY_W:0] HS_OFF = (XY_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XY_W:0] V_VIS  = (XY_W+1)'(V_ACTIVE);
  localparam logic [XY_W:0] VS_ON  = (XY_W+1)'(V_ACTIVE + V_FP);
  localparam logic [XY_W:0] VS_OFF = (XY_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_pol_e POL = (SYNC_POL != 0) ? SYNC_HIGH : SYNC_LOW;

  if (H_TOTAL > 2**XY_W || V_TOTAL > 2**XY_W ||
      TICK_DIV < 1 || PIPE < 0 || PIPE > 4) begin : g_cfg_err
    $error("vga_timing_gen_p: illegal parameter set");
  end

  logic [XY_W-1:0] h;
  logic [XY_W-1:0] v;
  logic [XY_W:0]   h_w;
  logic [XY_W:0]   v_w;
  sync_t           raw;
  sync_t           sync_q [PIPE+1];
  logic            vid_tap;
  logic [RGB_W-1:0] src;

  vga_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .p_tick(p_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (p_tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign pixel_x     = h;
  assign pixel_y     = v;
  assign frame_start = p_tick && (h == '0) && (v == '0);

  assign h_w = {1'b0, h};
  assign v_w = {1'b0, v};

  always_comb begin
    raw     = '0;
    raw.hs  = (h_w >= HS_ON) && (h_w < HS_OFF);
    raw.vs  = (v_w >= VS_ON) && (v_w < VS_OFF);
    raw.vid = (h_w < H_VIS) && (v_w < V_VIS);
  end

  // Stage k holds the flags for the coordinates k+1 ticks ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= PIPE; k++) sync_q[k] <= '0;
    end else if (p_tick) begin
      sync_q[0] <= raw;
      for (int k = 1; k <= PIPE; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // The RGB register samples one stage early so it lands with the flags.
  if (PIPE == 0) begin : g_tap0
    assign vid_tap = raw.vid;
  end else begin : g_tap
    assign vid_tap = sync_q[PIPE-1].vid;
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= BAR_CNT) ? H_ACTIVE / BAR_CNT : 1;

  logic [XY_W-1:0]  x_tap;
  logic [2:0]       bar_idx;
  logic [RGB_W-1:0] bar_rgb;

  if (PIPE == 0) begin : g_x0
    assign x_tap = h;
  end else begin : g_xd
    logic [XY_W-1:0] x_q [PIPE];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < PIPE; k++) x_q[k] <= '0;
      end else if (p_tick) begin
        x_q[0] <= h;
        for (int k = 1; k < PIPE; k++) x_q[k] <= x_q[k-1];
      end
    end
    assign x_tap = x_q[PIPE-1];
  end

  assign bar_idx = 3'(x_tap / XY_W'(BAR_W));

  always_comb begin
    bar_rgb = '0;
    for (int b = 0; b < RGB_W; b++) bar_rgb[b] = bar_idx[b % 3];
  end

  assign src = test_en ? bar_rgb : rgb_in;
`else
  assign src = rgb_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else if (p_tick) begin
      rgb <= vid_tap ? src : '0;
    end
  end

  assign video_on = sync_q[PIPE].vid;
  assign hsync    = (POL == SYNC_HIGH) ? sync_q[PIPE].hs : ~sync_q[PIPE].hs;
  assign vsync    = (POL == SYNC_HIGH) ? sync_q[PIPE].vs : ~sync_q[PIPE].vs;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// tb_vga_timing_gen_p: two configurations checked against a tick-count model.
// Config 0: 640-wide, short frame, DIV 2, PIPE 1; config 1: 800x600, DIV 1, PIPE 2.
module tb_vga_timing_gen_p;
  import vga_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b1;
  bit   live  = 1'b0;
  int   checks = 0;
  int   errs   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g,
                     input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s[cfg%0d]: got %0d expected %0d", nm, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int HA   = (g == 0) ? VGA640_H_ACTIVE : VGA800_H_ACTIVE;
    localparam int HF   = (g == 0) ? VGA640_H_FP     : VGA800_H_FP;
    localparam int HS   = (g == 0) ? VGA640_H_SYNC   : VGA800_H_SYNC;
    localparam int HB   = (g == 0) ? VGA640_H_BP     : VGA800_H_BP;
    localparam int VA   = (g == 0) ? 6 : VGA800_V_ACTIVE;
    localparam int VF   = (g == 0) ? 1 : VGA800_V_FP;
    localparam int VS   = (g == 0) ? 2 : VGA800_V_SYNC;
    localparam int VB   = (g == 0) ? 2 : VGA800_V_BP;
    localparam int POL  = g;
    localparam int DIV  = (g == 0) ? 2 : 1;
    localparam int PIPE = (g == 0) ? 1 : 2;
    localparam int XW   = (g == 0) ? 10 : 11;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;

    logic [2:0]    rgb_in, rgb;
    logic [XW-1:0] px, py;
    logic          pt, fs, hs, vs, vo;
    logic [2:0]    pg [PIPE];
    int            dtk;

    // Upstream pixel generator: colour = x[2:0], returned PIPE ticks later.
    always @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < PIPE; k++) pg[k] <= '0;
      end else if (pt) begin
        pg[0] <= px[2:0];
        for (int k = 1; k < PIPE; k++) pg[k] <= pg[k-1];
      end
    end
    assign rgb_in = pg[PIPE-1];

    always @(posedge clk) begin
      if (reset) dtk <= 0;
      else if (pt) dtk <= dtk + 1;
    end

    vga_timing_gen_p #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(POL), .TICK_DIV(DIV), .PIPE(PIPE),
      .RGB_W(3), .XY_W(XW)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
`ifdef VGA_TEST_PATTERN_EN
      .test_en    (g == 1),
`endif
      .rgb_in     (rgb_in),
      .pixel_x    (px),
      .pixel_y    (py),
      .p_tick     (pt),
      .frame_start(fs),
      .hsync      (hs),
      .vsync      (vs),
      .video_on   (vo),
      .rgb        (rgb)
    );

    // Model: n = enabled clks since reset, t = pixel ticks since reset.
    int n = 0;
    int t = 0;
    int s, hx, vy, col;
    bit ept, ehs, evs, evid;

    always @(posedge clk) begin
      if (reset) begin
        n = 0;
        t = 0;
      end else begin
        if (en && n >= 1 && n % DIV == 0) t++;
        if (en) n++;
      end
      #1;
      if (live) begin
        ept = en && n >= 1 && (n % DIV == 0);
        s   = t - PIPE - 1;
        ehs = 0; evs = 0; evid = 0; col = 0;
        if (s >= 0) begin
          hx   = s % HT;
          vy   = (s / HT) % VT;
          ehs  = hx >= HA + HF && hx < HA + HF + HS;
          evs  = vy >= VA + VF && vy < VA + VF + VS;
          evid = hx < HA && vy < VA;
          col  = hx % 8;
`ifdef VGA_TEST_PATTERN_EN
          if (g == 1) col = (hx / (HA / 8)) % 8;
`endif
          if (!evid) col = 0;
        end
        chk("pixel_x", g, px, t % HT);
        chk("pixel_y", g, py, (t / HT) % VT);
        chk("p_tick", g, pt, ept);
        chk("frame_start", g, fs,
            ept && (t % HT == 0) && ((t / HT) % VT == 0));
        chk("hsync", g, hs, (POL == 1) ? ehs : !ehs);
        chk("vsync", g, vs, (POL == 1) ? evs : !evs);
        chk("video_on", g, vo, evid);
        chk("rgb", g, rgb, col);
      end
    end
  end

  function automatic bit cond(input int sel, input int val);
    cond = 1'b0;
    case (sel)
      0:  cond = !g_cfg[0].hs;
      1:  cond = g_cfg[0].hs;
      2:  cond = int'(g_cfg[0].px) == val;
      3:  cond = !g_cfg[0].vs;
      4:  cond = g_cfg[0].vs;
      5:  cond = g_cfg[0].fs;
      6:  cond = g_cfg[0].px == 10'd700 && g_cfg[0].py == 10'd5;
      7:  cond = g_cfg[1].hs;
      8:  cond = !g_cfg[1].hs;
      9:  cond = int'(g_cfg[0].px) != val;
      10: cond = int'(g_cfg[1].px) == val;
      default: cond = 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int val, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (cond(sel, val)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL wait_%0d_%0d: not seen within %0d clk", sel, val, budget);
    end
  endtask

  initial begin
    int a;
    reset = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    live  = 1'b1;
    chk("rst_x", 0, g_cfg[0].px, 0);
    chk("rst_hsync", 0, g_cfg[0].hs, 1);
    chk("rst_vsync", 0, g_cfg[0].vs, 1);
    chk("rst_video", 0, g_cfg[0].vo, 0);
    chk("rst_rgb", 0, g_cfg[0].rgb, 0);
    chk("rst_ptick", 0, g_cfg[0].pt, 0);
    chk("rst_hsync", 1, g_cfg[1].hs, 0);
    fork
      begin : seq0
        int b;
        wait_for(0, 0, 3000);
        chk("hs_start_tick", 0, g_cfg[0].dtk, 658);
        b = g_cfg[0].dtk;
        wait_for(1, 0, 400);
        chk("hs_width", 0, g_cfg[0].dtk - b, 96);
        wait_for(2, 300, 2000);
        en = 1'b0;
        repeat (37) @(negedge clk);
        chk("hold_x", 0, g_cfg[0].px, 300);
        chk("hold_ptick", 0, g_cfg[0].pt, 0);
        en = 1'b1;
        wait_for(9, 300, 10);
        chk("resume_x", 0, g_cfg[0].px, 301);
        wait_for(3, 0, 12000);
        chk("vs_start_tick", 0, g_cfg[0].dtk, 5602);
        b = g_cfg[0].dtk;
        wait_for(4, 0, 4000);
        chk("vs_width", 0, g_cfg[0].dtk - b, 1600);
        wait_for(5, 0, 8000);
        chk("frame_period", 0, g_cfg[0].dtk, 8800);
        wait_for(6, 0, 12000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_x", 0, g_cfg[0].px, 0);
        chk("mid_rst_y", 0, g_cfg[0].py, 0);
        chk("mid_rst_rgb", 0, g_cfg[0].rgb, 0);
        chk("mid_rst_video", 0, g_cfg[0].vo, 0);
        chk("mid_rst_hsync", 0, g_cfg[0].hs, 1);
        chk("mid_rst_vsync", 0, g_cfg[0].vs, 1);
        @(negedge clk);
        chk("mid_rst_tick1", 0, g_cfg[0].pt, 0);
        @(negedge clk);
        chk("mid_rst_tick2", 0, g_cfg[0].pt, 1);
        repeat (2000) @(negedge clk);
      end
      begin : seq1
        wait_for(7, 0, 2000);
        a = g_cfg[1].dtk;
        chk("hs2_start_tick", 1, a, 843);
        wait_for(8, 0, 300);
        chk("hs2_width", 1, g_cfg[1].dtk - a, 128);
        wait_for(10, 103, 1200);
`ifdef VGA_TEST_PATTERN_EN
        chk("bar_x100", 1, g_cfg[1].rgb, 1);
        wait_for(10, 353, 400);
        chk("bar_x350", 1, g_cfg[1].rgb, 3);
        wait_for(10, 802, 600);
        chk("bar_x799", 1, g_cfg[1].rgb, 7);
`else
        chk("rgb_x100", 1, g_cfg[1].rgb, 4);
        wait_for(10, 353, 400);
        chk("rgb_x350", 1, g_cfg[1].rgb, 6);
        wait_for(10, 802, 600);
        chk("rgb_x799", 1, g_cfg[1].rgb, 7);
`endif
        chk("video_x799", 1, g_cfg[1].vo, 1);
        wait_for(10, 803, 20);
        chk("blank_x800", 1, g_cfg[1].rgb, 0);
        chk("blank_video", 1, g_cfg[1].vo, 0);
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
